reg_file: RTL



---
 rtl/reg_file.sv | 76 +++++++
 1 files changed

// File: rtl/reg_file.sv
// -----------------------------------------------------------------------------
// reg_file : architectural integer register file of the pipelined RISC-V core.
//
// Sink of the writeback interface. Two combinational read ports feed the ID
// stage, and one debug read port is provided. x0 is hardwired to zero. All
// other registers are cleared by reset.
//
// Ports
//   clk         core clock; all state updates happen on the rising edge
//   rst         synchronous, active-high reset; takes priority over a write
//   write_en    WB write strobe
//   write_reg   WB destination index
//   write_data  WB result
//   read_reg1   ID source index rs1
//   read_data1  value of rs1
//   read_reg2   ID source index rs2
//   read_data2  value of rs2
//   dbg_reg     debug index
//   dbg_data    value of dbg_reg; this port is never bypassed
//
// Build option
//   REGFILE_BYPASS_EN
//     When defined, a same-cycle write to the index being read is forwarded
//     to read_data1/2. This closes the WB->ID hazard without a stall.
//     When undefined, reads always return the stored value, and the hazard
//     unit must stall ID for one cycle.
// -----------------------------------------------------------------------------
module reg_file #(
  parameter  int REG_WIDTH = 32,
  parameter  int REG_COUNT = 32,
  localparam int REG_BITS  = $clog2(REG_COUNT)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        write_en,
  input  logic [REG_BITS-1:0]         write_reg,
  input  logic signed [REG_WIDTH-1:0] write_data,
  input  logic [REG_BITS-1:0]         read_reg1,
  input  logic [REG_BITS-1:0]         read_reg2,
  output logic signed [REG_WIDTH-1:0] read_data1,
  output logic signed [REG_WIDTH-1:0] read_data2,
  input  logic [REG_BITS-1:0]         dbg_reg,
  output logic signed [REG_WIDTH-1:0] dbg_data
);

  logic [REG_COUNT-1:0][REG_WIDTH-1:0] regs_q, regs_d;
  logic                                wr_hit;

  // A write to x0 is a legal no-op. It is filtered here so that the bypass
  // path and the storage path share the same qualification.
  assign wr_hit = write_en && (write_reg != '0);

  always_comb begin
    regs_d = regs_q;
    if (wr_hit) regs_d[write_reg] = write_data;
    regs_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) regs_q <= '0;
    else     regs_q <= regs_d;
  end

  // The index==0 gate on each read is redundant with the storage (x0 is
  // never written), but it keeps x0 reading zero independently of storage.
  always_comb begin
    read_data1 = (read_reg1 == '0) ? '0 : regs_q[read_reg1];
    read_data2 = (read_reg2 == '0) ? '0 : regs_q[read_reg2];
    dbg_data   = (dbg_reg   == '0) ? '0 : regs_q[dbg_reg];
`ifdef REGFILE_BYPASS_EN
    if (wr_hit && (write_reg == read_reg1)) read_data1 = write_data;
    if (wr_hit && (write_reg == read_reg2)) read_data2 = write_data;
`endif
  end

endmodule
